// File: rtl/caxi4interconnect_dwc_pkg.sv
// Shared types and command record layout for the
// AXI4 interconnect data-width-conversion path.
package caxi4interconnect_dwc_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01
    } burst_e;

    localparam int CMD_LEN_W     = 8;
    localparam int CMD_SIZE_W    = 3;
    localparam int CMD_BURST_W   = 2;
    localparam int CMD_LEN_OFS   = 0;
    localparam int CMD_SIZE_OFS  = CMD_LEN_OFS + CMD_LEN_W;
    localparam int CMD_BURST_OFS = CMD_SIZE_OFS + CMD_SIZE_W;
    localparam int CMD_ADDR_OFS  = CMD_BURST_OFS + CMD_BURST_W;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int cmd_width(input int addr_w);
        return CMD_ADDR_OFS + addr_w;
    endfunction

endpackage

// File: rtl/caxi4interconnect_dwc_cmd_fifo.sv
// Synchronous command FIFO between the AW-side
// converter and the W-data downsizer.
module caxi4interconnect_dwc_cmd_fifo
    import caxi4interconnect_dwc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PW = clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Extra pointer bit tells full from empty.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign dout  = mem[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr[PW-1:0]] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/caxi4interconnect_dwc_wdata_downsizer.sv
// Splits wide W beats into narrow slave beats, with
// WLAST regenerated from the queued burst command.
module caxi4interconnect_dwc_wdata_downsizer
    import caxi4interconnect_dwc_pkg::*;
#(
    parameter int DATA_WIDTH_IN  = 128,
    parameter int DATA_WIDTH_OUT = 32,
    parameter int ID_WIDTH       = 1,
    parameter int USER_WIDTH     = 1,
    parameter int CMD_FIFO_DEPTH = 4
) (
    input  logic                          ACLK,
    input  logic                          sysReset,
    input  logic                          CMD_VALID,
    output logic                          CMD_READY,
    input  logic [clog2(DATA_WIDTH_IN/8)-1:0] CMD_ADDR,
    input  logic [2:0]                    CMD_SIZE,
    input  logic [7:0]                    CMD_LEN,
    input  logic [1:0]                    CMD_BURST,
    input  logic [ID_WIDTH-1:0]           MASTER_WID,
    input  logic [DATA_WIDTH_IN-1:0]      MASTER_WDATA,
    input  logic [DATA_WIDTH_IN/8-1:0]    MASTER_WSTRB,
    input  logic [USER_WIDTH-1:0]         MASTER_WUSER,
    input  logic                          MASTER_WLAST,
    input  logic                          MASTER_WVALID,
    output logic                          MASTER_WREADY,
    output logic [ID_WIDTH-1:0]           SLAVE_WID,
    output logic [DATA_WIDTH_OUT-1:0]     SLAVE_WDATA,
    output logic [DATA_WIDTH_OUT/8-1:0]   SLAVE_WSTRB,
    output logic [USER_WIDTH-1:0]         SLAVE_WUSER,
    output logic                          SLAVE_WLAST,
    output logic                          SLAVE_WVALID,
    input  logic                          SLAVE_WREADY,
    output logic                          WLAST_ERR
);

    localparam int IB    = DATA_WIDTH_IN / 8;
    localparam int OB    = DATA_WIDTH_OUT / 8;
    localparam int RATIO = IB / OB;
    localparam int AW    = clog2(IB);
    localparam int OW    = clog2(OB);
    localparam int SW    = clog2(RATIO);
    localparam int CW    = cmd_width(AW);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SPLIT
    } state_e;

    state_e                  state;
    logic                    rst_q;
    logic [CW-1:0]           cmd_din;
    logic [CW-1:0]           cmd_dout;
    logic                    cmd_push;
    logic                    cmd_pop;
    logic                    fifo_full;
    logic                    fifo_empty;

    logic [AW-1:0]           addr;
    logic [2:0]              size;
    logic [7:0]              len;
    logic [1:0]              burst;
    logic [7:0]              beat_cnt;
    logic [DATA_WIDTH_IN-1:0] hold_data;
    logic [IB-1:0]           hold_strb;
    logic [SW-1:0]           slice;
    logic [SW-1:0]           last_slice;

    logic                    last_beat;
    logic                    slice_end;
    logic                    burst_done;
    logic [SW-1:0]           slice_nxt;
    logic [SW-1:0]           first_slice;
    logic [SW-1:0]           last_calc;
    logic [AW:0]             step;
    logic [AW-1:0]           mask;
    logic [AW-1:0]           a_sz;
    logic [AW:0]             span;
    logic [AW:0]             nxt_addr;

    function automatic logic [DATA_WIDTH_OUT-1:0] pick_d(
        input logic [DATA_WIDTH_IN-1:0] d,
        input logic [SW-1:0]            k
    );
        return d[int'(k)*DATA_WIDTH_OUT +: DATA_WIDTH_OUT];
    endfunction

    function automatic logic [OB-1:0] pick_s(
        input logic [IB-1:0] s,
        input logic [SW-1:0] k
    );
        return s[int'(k)*OB +: OB];
    endfunction

    always_comb begin
        cmd_din = '0;
        cmd_din[CMD_LEN_OFS +: CMD_LEN_W]     = CMD_LEN;
        cmd_din[CMD_SIZE_OFS +: CMD_SIZE_W]   = CMD_SIZE;
        cmd_din[CMD_BURST_OFS +: CMD_BURST_W] = CMD_BURST;
        cmd_din[CMD_ADDR_OFS +: AW]           = CMD_ADDR;
    end

    // Held low for one extra cycle after reset release.
    assign CMD_READY = !fifo_full && !sysReset && !rst_q;
    assign cmd_push  = CMD_VALID && CMD_READY;

    assign MASTER_WREADY = (state == LOAD) && !sysReset;

    assign last_beat  = (beat_cnt == len);
    assign slice_end  = (slice == last_slice);
    assign slice_nxt  = slice + 1'b1;
    assign burst_done = (state == SPLIT) && SLAVE_WREADY &&
                        slice_end && last_beat;
    assign cmd_pop    = !sysReset && !fifo_empty &&
                        ((state == IDLE) || burst_done);

    always_comb begin
        step        = {{AW{1'b0}}, 1'b1} << size;
        mask        = step[AW-1:0] - 1'b1;
        a_sz        = addr & ~mask;
        span        = {1'b0, a_sz} + step - 1'b1;
        nxt_addr    = {1'b0, a_sz} + step;
        first_slice = addr[AW-1:OW];
        last_calc   = first_slice;
        if (int'(size) >= OW) begin
            last_calc = span[AW-1:OW];
        end
    end

    caxi4interconnect_dwc_cmd_fifo #(
        .WIDTH (CW),
        .DEPTH (CMD_FIFO_DEPTH)
    ) u_cmd_fifo (
        .clk   (ACLK),
        .rst   (sysReset),
        .push  (cmd_push),
        .din   (cmd_din),
        .pop   (cmd_pop),
        .dout  (cmd_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge ACLK) begin
        rst_q <= sysReset;
        if (sysReset) begin
            state        <= IDLE;
            addr         <= '0;
            size         <= '0;
            len          <= '0;
            burst        <= '0;
            beat_cnt     <= '0;
            hold_data    <= '0;
            hold_strb    <= '0;
            slice        <= '0;
            last_slice   <= '0;
            SLAVE_WID    <= '0;
            SLAVE_WDATA  <= '0;
            SLAVE_WSTRB  <= '0;
            SLAVE_WUSER  <= '0;
            SLAVE_WLAST  <= 1'b0;
            SLAVE_WVALID <= 1'b0;
            WLAST_ERR    <= 1'b0;
        end else begin
            WLAST_ERR <= 1'b0;
            if (cmd_pop) begin
                addr     <= cmd_dout[CMD_ADDR_OFS +: AW];
                size     <= cmd_dout[CMD_SIZE_OFS +: CMD_SIZE_W];
                len      <= cmd_dout[CMD_LEN_OFS +: CMD_LEN_W];
                burst    <= cmd_dout[CMD_BURST_OFS +: CMD_BURST_W];
                beat_cnt <= '0;
            end
            unique case (state)
                IDLE: begin
                    if (cmd_pop) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    if (MASTER_WVALID) begin
                        hold_data    <= MASTER_WDATA;
                        hold_strb    <= MASTER_WSTRB;
                        slice        <= first_slice;
                        last_slice   <= last_calc;
                        SLAVE_WID    <= MASTER_WID;
                        SLAVE_WUSER  <= MASTER_WUSER;
                        SLAVE_WDATA  <= pick_d(MASTER_WDATA, first_slice);
                        SLAVE_WSTRB  <= pick_s(MASTER_WSTRB, first_slice);
                        SLAVE_WVALID <= 1'b1;
                        SLAVE_WLAST  <= last_beat &&
                                        (first_slice == last_calc);
                        WLAST_ERR    <= (MASTER_WLAST != last_beat);
                        state        <= SPLIT;
                    end
                end
                SPLIT: begin
                    if (SLAVE_WREADY) begin
                        if (slice_end) begin
                            SLAVE_WVALID <= 1'b0;
                            SLAVE_WLAST  <= 1'b0;
                            if (last_beat) begin
                                state <= cmd_pop ? LOAD : IDLE;
                            end else begin
                                beat_cnt <= beat_cnt + 1'b1;
                                if (burst != BURST_FIXED) begin
                                    addr <= nxt_addr[AW-1:0];
                                end
                                state <= LOAD;
                            end
                        end else begin
                            slice       <= slice_nxt;
                            SLAVE_WDATA <= pick_d(hold_data, slice_nxt);
                            SLAVE_WSTRB <= pick_s(hold_strb, slice_nxt);
                            SLAVE_WLAST <= last_beat &&
                                           (slice_nxt == last_slice);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
